// File: rtl/k005297_pkg.sv
// Shared constants and ROT20 slot decoding for the K005297 page datapath
// (absolute page counter, page comparator, page register).
package k005297_pkg;

  localparam int          ABSPG_WIDTH = 12;
  localparam logic [11:0] ABSPG_MAX   = 12'd2052;

  localparam int SLOT_BIT0   = 0;
  localparam int SLOT_LATCH  = 12;
  localparam int SLOT_ARM    = 19;
  localparam int ROT20_SLOTS = 20;

  typedef struct packed {
    logic       vld;
    logic [4:0] idx;
  } slot_t;

  // Lowest active (zero) bit wins, so a malformed multi-hot input still
  // yields a single slot.
  function automatic slot_t rot20_decode(input logic [ROT20_SLOTS-1:0] rot20_n);
    slot_t s;
    s = '0;
    for (int k = ROT20_SLOTS - 1; k >= 0; k--) begin
      if (!rot20_n[k]) begin
        s.vld = 1'b1;
        s.idx = 5'(k);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/FA.sv
// One-bit full adder cell shared across the K005297 serial datapaths.
module FA (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic COUT
);

  assign S    = A ^ B ^ CIN;
  assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/k005297_abspgcntr.sv
// Absolute page counter: 12-bit circulating serial register streamed LSB-first
// on ROT20 slots 0..11, incremented once per armed page event, wrapping at ABSPG_MAX.
module k005297_abspgcntr #(
  parameter int               WIDTH     = k005297_pkg::ABSPG_WIDTH,
  parameter logic [WIDTH-1:0] ABSPG_MAX = k005297_pkg::ABSPG_MAX
) (
  input  logic             i_MCLK,
  input  logic             i_RST,
  input  logic             i_CLK2M_PCEN_n,
  input  logic [19:0]      i_ROT20_n,
  input  logic             i_PGADV,
  input  logic             i_PGRST,
  output logic             o_ABSPGCNTR_LSB,
  output logic [WIDTH-1:0] o_ABSPG,
  output logic             o_PGWRAP
);

  import k005297_pkg::*;

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr;
  logic             c;
  logic             inc_pend, clr_pend;
  logic             inc_arm, clr_arm;
  logic             eq_acc;
  logic             wrap_flg;

  slot_t cur;
  logic  en, in_data, is_latch, is_arm;
  logic  sum, cout;
  logic  newbit, max_bit;
  logic  inc_req, clr_req;

  assign cur      = rot20_decode(i_ROT20_n);
  assign en       = ~i_CLK2M_PCEN_n;
  assign in_data  = cur.vld && (cur.idx < 5'(WIDTH));
  assign is_latch = cur.vld && (cur.idx == 5'(SLOT_LATCH));
  assign is_arm   = cur.vld && (cur.idx == 5'(SLOT_ARM));

  FA u_fa (
    .A    (sr[0]),
    .B    (1'b0),
    .CIN  (c),
    .S    (sum),
    .COUT (cout)
  );

  always_comb begin
    // NOTE: combinational outputs get a default first so no path infers a latch.
    newbit  = sum;
    max_bit = ABSPG_MAX[cur.idx[IW-1:0]];
    // A request in the arming cycle itself is folded straight into the arm.
    inc_req = inc_pend | i_PGADV;
    clr_req = clr_pend | i_PGRST;
    // Clear dominates; an increment from ABSPG_MAX writes zero without rippling.
    if (clr_arm || (inc_arm && wrap_flg)) newbit = 1'b0;
  end

  assign o_ABSPGCNTR_LSB = in_data & sr[0];

  always_ff @(posedge i_MCLK) begin
    // NOTE: reset is synchronous and overrides the clock enable, so a
    // partially shifted frame is discarded on the very next edge.
    if (i_RST) begin
      sr       <= '0;
      c        <= 1'b0;
      inc_pend <= 1'b0;
      clr_pend <= 1'b0;
      inc_arm  <= 1'b0;
      clr_arm  <= 1'b0;
      eq_acc   <= 1'b0;
      wrap_flg <= 1'b0;
      o_ABSPG  <= '0;
      o_PGWRAP <= 1'b0;
    end else if (en && cur.vld) begin
      // NOTE: all state uses non-blocking updates so every branch below sees
      // the pre-edge values of sr, c and the flags.
      o_PGWRAP <= 1'b0;

      if (is_arm) begin
        inc_arm  <= inc_req;
        clr_arm  <= clr_req;
        c        <= inc_req & ~clr_req;
        eq_acc   <= 1'b1;
        inc_pend <= 1'b0;
        clr_pend <= 1'b0;
      end else begin
        if (i_PGADV) inc_pend <= 1'b1;
        if (i_PGRST) clr_pend <= 1'b1;
      end

      if (in_data) begin
        c      <= cout;
        sr     <= {newbit, sr[WIDTH-1:1]};
        eq_acc <= eq_acc & (newbit == max_bit);
      end

      if (is_latch) begin
        o_ABSPG  <= sr;
        wrap_flg <= eq_acc;
        o_PGWRAP <= inc_arm & wrap_flg & ~clr_arm;
      end
    end
  end

endmodule

// File: tb/tb_k005297_abspgcntr.sv
// Directed bench for the absolute page counter: reset, increment latency,
// carry ripple, wrap at 2052, clear priority, request collapse, freeze, reset mid-frame.
module tb_k005297_abspgcntr;

  logic        i_MCLK;
  logic        i_RST;
  logic        i_CLK2M_PCEN_n;
  logic [19:0] i_ROT20_n;
  logic        i_PGADV;
  logic        i_PGRST;
  logic        o_ABSPGCNTR_LSB;
  logic [11:0] o_ABSPG;
  logic        o_PGWRAP;

  k005297_abspgcntr dut (
    .i_MCLK          (i_MCLK),
    .i_RST           (i_RST),
    .i_CLK2M_PCEN_n  (i_CLK2M_PCEN_n),
    .i_ROT20_n       (i_ROT20_n),
    .i_PGADV         (i_PGADV),
    .i_PGRST         (i_PGRST),
    .o_ABSPGCNTR_LSB (o_ABSPGCNTR_LSB),
    .o_ABSPG         (o_ABSPG),
    .o_PGWRAP        (o_PGWRAP)
  );

  initial i_MCLK = 1'b0;
  always #5 i_MCLK = ~i_MCLK;

  int          checks;
  int          errors;
  int          slot;
  int          wrap_count;
  int          model;
  logic [19:0] lsb_hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One enabled cycle on the current slot; the serial bit is sampled before the edge.
  task automatic tick(input logic adv, input logic pgrst, input logic rst);
    i_RST          = rst;
    i_CLK2M_PCEN_n = 1'b0;
    i_ROT20_n      = ~(20'd1 << slot);
    i_PGADV        = adv;
    i_PGRST        = pgrst;
    #1;
    lsb_hist[slot] = o_ABSPGCNTR_LSB;
    @(posedge i_MCLK);
    #1;
    if (o_PGWRAP === 1'b1) wrap_count++;
    slot = (slot == 19) ? 0 : slot + 1;
  endtask

  // A cycle that must not move any state: requests are driven high throughout.
  task automatic stall(input logic en_n, input logic [19:0] rot_n);
    i_RST          = 1'b0;
    i_CLK2M_PCEN_n = en_n;
    i_ROT20_n      = rot_n;
    i_PGADV        = 1'b1;
    i_PGRST        = 1'b1;
    @(posedge i_MCLK);
    #1;
    if (o_PGWRAP === 1'b1) wrap_count++;
  endtask

  task automatic frame(input logic [19:0] adv_m, input logic [19:0] pgrst_m);
    for (int s = 0; s < 20; s++) tick(adv_m[slot], pgrst_m[slot], 1'b0);
  endtask

  function automatic int next_val(input int v);
    return (v == 2052) ? 0 : v + 1;
  endfunction

  // One advance per frame, then an idle frame so the last write is latched.
  task automatic advance_to(input int target);
    while (model != target) begin
      frame(20'h00008, 20'h0);
      model = next_val(model);
    end
    frame(20'h0, 20'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    slot           = 0;
    wrap_count     = 0;
    model          = 0;
    lsb_hist       = '0;
    i_RST          = 1'b1;
    i_CLK2M_PCEN_n = 1'b1;
    i_ROT20_n      = '1;
    i_PGADV        = 1'b0;
    i_PGRST        = 1'b0;

    // Reset for 3 cycles, then two idle frames.
    repeat (3) @(posedge i_MCLK);
    #1;
    i_RST = 1'b0;
    check("rst_abspg", 32'(o_ABSPG), 0);
    check("rst_pgwrap", 32'(o_PGWRAP), 0);
    check("rst_lsb", 32'(o_ABSPGCNTR_LSB), 0);
    frame(20'h0, 20'h0);
    check("rst_f1_serial", 32'(lsb_hist), 0);
    frame(20'h0, 20'h0);
    check("rst_f2_serial", 32'(lsb_hist), 0);
    check("rst_f2_abspg", 32'(o_ABSPG), 0);
    check("rst_wraps", 32'(wrap_count), 0);

    // Single advance at slot 5 of F; visible at slot 12 of F+1, streamed in F+2.
    frame(20'h00020, 20'h0);
    repeat (12) tick(1'b0, 1'b0, 1'b0);
    check("adv1_pre_latch", 32'(o_ABSPG), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("adv1_latched", 32'(o_ABSPG), 1);
    repeat (7) tick(1'b0, 1'b0, 1'b0);
    check("adv1_f1_old_serial", 32'(lsb_hist), 0);
    frame(20'h0, 20'h0);
    check("adv1_f2_serial", 32'(lsb_hist), 32'h00001);
    model = 1;

    // Request exactly at slot 19 keeps the same latency.
    frame(20'h80000, 20'h0);
    frame(20'h0, 20'h0);
    check("adv_slot19", 32'(o_ABSPG), 2);
    model = 2;

    // Carry ripple 255 -> 256.
    advance_to(255);
    check("pre_carry", 32'(o_ABSPG), 255);
    frame(20'h0, 20'h0);
    check("val255_serial", 32'(lsb_hist), 32'h000FF);
    frame(20'h00008, 20'h0);
    frame(20'h0, 20'h0);
    check("carry_abspg", 32'(o_ABSPG), 256);
    frame(20'h0, 20'h0);
    check("carry_serial", 32'(lsb_hist), 32'h00100);
    model = 256;

    // Disabled cycles mid-shift and slot-less cycles must freeze everything.
    for (int s = 0; s < 20; s++) begin
      if (s == 5) begin
        repeat (3) stall(1'b1, ~(20'd1 << 5));
        repeat (3) stall(1'b0, 20'hFFFFF);
      end
      tick(1'b0, 1'b0, 1'b0);
    end
    check("freeze_serial", 32'(lsb_hist), 32'h00100);
    frame(20'h0, 20'h0);
    check("freeze_abspg", 32'(o_ABSPG), 256);

    // Count up to 2052, then wrap to 0 with one PGWRAP pulse at slot 12.
    advance_to(2052);
    check("at_max", 32'(o_ABSPG), 2052);
    check("no_wrap_yet", 32'(wrap_count), 0);
    frame(20'h00008, 20'h0);
    repeat (12) tick(1'b0, 1'b0, 1'b0);
    check("wrap_pre_pulse", 32'(o_PGWRAP), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("wrap_pulse", 32'(o_PGWRAP), 1);
    check("wrap_abspg", 32'(o_ABSPG), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("wrap_pulse_end", 32'(o_PGWRAP), 0);
    repeat (6) tick(1'b0, 1'b0, 1'b0);
    check("wrap_old_serial", 32'(lsb_hist), 32'h00804);
    frame(20'h0, 20'h0);
    check("wrap_new_serial", 32'(lsb_hist), 0);
    check("wrap_count", 32'(wrap_count), 1);
    model = 0;

    // Clear dominates three collapsed advances in the same frame.
    advance_to(100);
    check("at_100_a", 32'(o_ABSPG), 100);
    frame(20'h08084, 20'h00400);
    frame(20'h0, 20'h0);
    check("clear_priority", 32'(o_ABSPG), 0);
    model = 0;

    // Three advances in one frame collapse to one increment.
    advance_to(100);
    check("at_100_b", 32'(o_ABSPG), 100);
    frame(20'h08084, 20'h0);
    frame(20'h0, 20'h0);
    check("collapse", 32'(o_ABSPG), 101);
    model = 101;

    // Reset at slot 6 while streaming 1234, then count from zero again.
    advance_to(1234);
    check("at_1234", 32'(o_ABSPG), 1234);
    repeat (6) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("midrst_abspg", 32'(o_ABSPG), 0);
    check("midrst_pgwrap", 32'(o_PGWRAP), 0);
    check("midrst_lsb", 32'(o_ABSPGCNTR_LSB), 0);
    repeat (13) tick(1'b0, 1'b0, 1'b0);
    frame(20'h0, 20'h0);
    check("midrst_serial", 32'(lsb_hist), 0);
    check("midrst_hold", 32'(o_ABSPG), 0);
    frame(20'h00008, 20'h0);
    frame(20'h0, 20'h0);
    check("post_rst_adv", 32'(o_ABSPG), 1);
    check("final_wraps", 32'(wrap_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/k005297_abspgcntr.md
# k005297_abspgcntr

Absolute page counter for the K005297 bubble memory controller. Holds the 12-bit absolute page position of the bubble loop as a circulating serial register. Streams the value LSB-first on the 20-slot ROT20 timing into the page comparator. Advances by one per page event, wrapping at 2052 to 0.

## Interface
Parameters:
- `WIDTH`, 12, counter width in bits.
- `ABSPG_MAX`, 2052, last valid absolute page; the next increment yields 0.

Ports:
- `i_MCLK`  in  1  master clock; the only clock.
- `i_RST`  in  1  reset, synchronous, active-high.
- `i_CLK2M_PCEN_n`  in  1  2 MHz clock enable, active-low. All state except reset advances only when it is 0.
- `i_ROT20_n`  in  20  one-hot active-low slot timing. Slot k is active when bit k is 0.
- `i_PGADV`  in  1  page-advance request, active-high, sampled on enabled cycles.
- `i_PGRST`  in  1  page-zero request, active-high, sampled on enabled cycles.
- `o_ABSPGCNTR_LSB`  out  1  serial counter bit; bit k is driven during slot k, for k = 0..11.
- `o_ABSPG`  out  12  parallel counter value, updated at slot 12.
- `o_PGWRAP`  out  1  one-enabled-cycle pulse when the written value wraps to 0.

## Operation
- **State:**
  - `sr[11:0]` circulating value.
  - `c` serial carry.
  - `inc_pend`, `clr_pend` request latches.
  - `inc_arm`, `clr_arm` frame-armed flags.
  - `eq_acc` running match to `ABSPG_MAX`.
  - `wrap_flg`.
- **Request capture:** `i_PGADV` sets `inc_pend`; `i_PGRST` sets `clr_pend`.
  - Multiple `i_PGADV` pulses before arming collapse to one increment.
- **Slot 19 (frame arm):**
  - `inc_arm <= inc_pend`, `clr_arm <= clr_pend`, `c <= inc_pend & ~clr_pend`, `eq_acc <= 1`.
  - Both pend latches clear. A request arriving in this same cycle is armed directly and does not remain pending.
- **Slots 0..11, bit k:**
  - `o_ABSPGCNTR_LSB = sr[0]`.
  - `newbit` is 0 if `clr_arm`, or if (`inc_arm & wrap_flg`); otherwise it is `sr[0]^c`.
  - `c <= sr[0] & c`.
  - `sr <= {newbit, sr[11:1]}`.
  - `eq_acc <= eq_acc & (newbit == ABSPG_MAX[k])`.
- **Slot 12:**
  - `o_ABSPG <= sr`.
  - `wrap_flg <= eq_acc`, meaning the stored value equals 2052.
  - `o_PGWRAP` pulses if `inc_arm & old wrap_flg & ~clr_arm`.
- **Slots 13..18:** hold; `o_ABSPGCNTR_LSB = 0`.
- **Clear priority:** clear dominates increment within the same frame.
- **No slot active** (`i_ROT20_n` all 1s): hold all state.
- **Reset value (all 0):** `sr`, all flags, `c`, `o_ABSPG`, `o_PGWRAP`, `o_ABSPGCNTR_LSB`. `wrap_flg` resets to 0.

## Timing
- **Frame:** 20 enabled cycles, slot 0 through slot 19.
- **Increment latency:** a request on any enabled cycle of frame F arms at slot 19 of F.
  - The new value is written during slots 0..11 of F+1; the old value is streamed during those slots.
  - The new value appears on `o_ABSPG` at slot 12 of F+1 and is streamed in F+2.
- **Slot-19 edge case:** a request exactly at slot 19 of F follows the same latency as above.
- **Wrap:** an increment at 2052 writes 0 with no carry ripple, and `o_PGWRAP` is high for one enabled cycle at slot 12.
- **Reset mid-frame:** `i_RST` clears everything on the next `i_MCLK` edge regardless of the enable. Slot tracking resumes from `i_ROT20_n` immediately. A partially written frame is discarded.
- **Enable low between edges:** state is frozen with no partial shift.

## Structure
- **Package `k005297_pkg`:**
  - `ABSPG_WIDTH=12`, `ABSPG_MAX=12'd2052`.
  - Slot constants `SLOT_BIT0=0`, `SLOT_LATCH=12`, `SLOT_ARM=19`.
  - These are shared with the page comparator and page register.
- **Serial adder:** reuses the existing `FA` cell, one instance with A=`sr[0]`, B=0, CIN=`c`.
- **No further sub-modules.**

## Test plan
- **Reset:** assert `i_RST` for 3 cycles, then run 2 frames → `o_ABSPG=0`, `o_ABSPGCNTR_LSB=0` in every slot, `o_PGWRAP=0`.
- **Single advance:** one `i_PGADV` at slot 5 of F.
  - `o_ABSPG=1` at slot 12 of F+1.
  - In F+2 the serial output is 1 at slot 0 and 0 at slots 1..11.
- **Carry ripple:** preset to 255 via advances, then one `i_PGADV` → `o_ABSPG=256`, serial output 1 only at slot 8.
- **Wrap:** from 0, issue 2052 advances (one per frame) → value 2052. One more → `o_ABSPG=0`, `o_PGWRAP` pulses once at slot 12.
- **Priority and collapse:**
  - `i_PGADV` ×3 plus `i_PGRST` within one frame at value 100 → value 0.
  - `i_PGADV` ×3 alone at value 100 → value 101.
- **Reset mid-stream:** at value 1234, assert `i_RST` at slot 6 → all outputs 0 on the next edge. One `i_PGADV` afterwards → value 1.
